full_adder: RTL and testbench

- Registered ripple-carry adder; with default WIDTH=1 it is a clocked 1-bit full adder.
- Computes a + b + carry and presents sum and carryout one clock after inputs are sampled.
- Leaf arithmetic cell for the add/sub datapath; the 4-bit add/sub unit instantiates it.

---
 rtl/adder_pkg.sv | 14 +
 rtl/fa_bit.sv | 17 +
 rtl/full_adder.sv | 67 ++++++
 tb/tb_full_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the add/sub datapath: operand width limit and the
// result record handed between arithmetic cells and their parent units.
package adder_pkg;

  localparam int unsigned ADD_MAX_WIDTH  = 64;
  localparam int unsigned ADD_UNIT_WIDTH = 4;

  // Result of one add/sub unit slice, carry-out kept above the sum bits.
  typedef struct packed {
    logic                      carryout;
    logic [ADD_UNIT_WIDTH-1:0] sum;
  } add_result_t;

endpackage

// File: rtl/fa_bit.sv
// Purely combinational 1-bit full adder; one link of the ripple-carry chain.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  // Generate when both operands are set, propagate an incoming carry otherwise.
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH bits producing {carryout, sum} = a + b + carry,
// either through an output register (latency 1) or straight through.
module full_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  if (WIDTH < 1 || WIDTH > ADD_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH must be in 1..%0d", ADD_MAX_WIDTH);
  end

  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_d;
  logic             carryout_d;

  assign carry_chain[0] = carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry_chain[i]),
      .s   (sum_d[i]),
      .cout(carry_chain[i+1])
    );
  end

  assign carryout_d = carry_chain[WIDTH];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carryout_q;

    // NOTE: reset is synchronous and wins over the data path, so a result
    // captured just before rst rises is overwritten and never resurfaces.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q      <= '0;
        carryout_q <= 1'b0;
      end else begin
        sum_q      <= sum_d;
        carryout_q <= carryout_d;
      end
    end

    assign sum      = sum_q;
    assign carryout = carryout_q;
  end else begin : g_comb
    logic unused_ports;

    // Clock and reset stay on the interface so both variants share a footprint.
    assign unused_ports = clk ^ rst;
    assign sum          = sum_d;
    assign carryout     = carryout_d;
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: registered 1/4/16-bit instances plus a
// combinational 1-bit instance, checked against plain integer addition.
module tb_full_adder;

  logic        clk;
  logic        rst;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        c_r;

  logic        s1;
  logic        co1;
  logic [3:0]  s4;
  logic        co4;
  logic [15:0] s16;
  logic        co16;

  logic        ac;
  logic        bc;
  logic        cc;
  logic        sc;
  logic        coc;

  int checks   = 0;
  int failures = 0;

  logic [16:0] q1[$];
  logic [16:0] q4[$];
  logic [16:0] q16[$];
  logic [16:0] qc[$];
  event        ev_c;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .a(a_r[0:0]), .b(b_r[0:0]), .carry(c_r),
    .sum(s1), .carryout(co1)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) dut_w4 (
    .clk(clk), .rst(rst), .a(a_r[3:0]), .b(b_r[3:0]), .carry(c_r),
    .sum(s4), .carryout(co4)
  );

  full_adder #(.WIDTH(16), .REG_OUT(1'b1)) dut_w16 (
    .clk(clk), .rst(rst), .a(a_r), .b(b_r), .carry(c_r),
    .sum(s16), .carryout(co16)
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .a(ac), .b(bc), .carry(cc),
    .sum(sc), .carryout(coc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {carryout, sum} for a w-bit adder: integer sum of the masked operands.
  function automatic logic [16:0] ref_add(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic cv,
                                          input bit r);
    logic [16:0] mask;
    if (r) return 17'd0;
    mask = (17'd1 << w) - 17'd1;
    return ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {16'd0, cv};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv);
    @(negedge clk);
    rst = r;
    a_r = av;
    b_r = bv;
    c_r = cv;
    q1.push_back(ref_add(1, av, bv, cv, r));
    q4.push_back(ref_add(4, av, bv, cv, r));
    q16.push_back(ref_add(16, av, bv, cv, r));
  endtask

  // Registered monitor: each pushed entry is due just after the next rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() != 0) check("w1", {15'd0, co1, s1}, q1.pop_front());
      if (q4.size() != 0) check("w4", {12'd0, co4, s4}, q4.pop_front());
      if (q16.size() != 0) check("w16", {co16, s16}, q16.pop_front());
    end
  end

  // Combinational monitor: checks whenever the driver announces settled inputs.
  initial begin
    forever begin
      @(ev_c);
      if (qc.size() != 0) check("comb", {15'd0, coc, sc}, qc.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int          tt[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
  logic [2:0]  v;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    rst = 1'b1;
    a_r = '0;
    b_r = '0;
    c_r = 1'b0;
    ac  = 1'b0;
    bc  = 1'b0;
    cc  = 1'b0;

    // Reset held with all inputs high, then released with the same inputs.
    drive(1'b1, 16'h0001, 16'h0001, 1'b1);
    drive(1'b1, 16'h0001, 16'h0001, 1'b1);
    drive(1'b0, 16'h0001, 16'h0001, 1'b1);

    // Full 1-bit truth table in the listed order.
    for (int i = 0; i < 8; i++) begin
      v = tt[i][2:0];
      drive(1'b0, {15'd0, v[2]}, {15'd0, v[1]}, v[0]);
    end

    // Back-to-back alternation of 000 and 111.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      else            drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    end

    // Mid-stream reset: 110 result shows, 101 result is discarded.
    drive(1'b0, 16'h0001, 16'h0001, 1'b0);
    drive(1'b1, 16'h0001, 16'h0000, 1'b1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);

    // Width-4 corner vectors and full wrap-around on every width.
    drive(1'b0, 16'h000F, 16'h0000, 1'b1);
    drive(1'b0, 16'h0007, 16'h0008, 1'b0);
    drive(1'b0, 16'h000F, 16'h000F, 1'b1);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b0, 16'h8000, 16'h8000, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 16'hFFFF;
      drive($urandom_range(0, 15) == 0, ra, rb, 1'($urandom));
    end

    repeat (4) @(posedge clk);
    #2;
    check("w1_drained", 17'(q1.size()), 17'd0);
    check("w4_drained", 17'(q4.size()), 17'd0);
    check("w16_drained", 17'(q16.size()), 17'd0);

    // Combinational variant: truth table then random, 10 ns apart.
    for (int i = 0; i < 8; i++) begin
      v  = tt[i][2:0];
      ac = v[2];
      bc = v[1];
      cc = v[0];
      qc.push_back(ref_add(1, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'b0));
      #1;
      -> ev_c;
      #9;
    end
    for (int i = 0; i < 16; i++) begin
      v  = 3'($urandom);
      ac = v[2];
      bc = v[1];
      cc = v[0];
      qc.push_back(ref_add(1, {15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'b0));
      #1;
      -> ev_c;
      #9;
    end
    check("comb_drained", 17'(qc.size()), 17'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
